// File: rtl/nibble_serial_adder.sv
// -----------------------------------------------------------------------------
// nibble_serial_adder
//
// Purpose: computes a wide sum s = a + b + cin one 4-bit nibble per clock. A
// single 4-bit carry-select slice is reused for every nibble. The carry out of
// nibble k is registered and becomes the carry-in of nibble k+1 on the next
// cycle, so no combinational carry path runs between nibbles.
//
// Parameters:
//   NIBBLES  number of nibbles (1..16); operand width W = 4*NIBBLES
//
// Ports:
//   clk    in   1  clock, rising edge
//   rst_n  in   1  asynchronous active-low reset
//   start  in   1  request a new add (sampled only in IDLE or DONE)
//   a, b   in   W  operands, latched on an accepted start
//   cin    in   1  carry into nibble 0, latched on an accepted start
//   s      out  W  sum, valid from done until the next accepted start
//   cy     out  1  carry out of the top nibble (bit W of a+b+cin)
//   ovf    out  1  two's-complement signed overflow
//   busy   out  1  high while nibbles are being processed
//   done   out  1  one-cycle pulse when s/cy/ovf become valid
// -----------------------------------------------------------------------------

// 4-bit carry-select slice: the low two bits ripple from cin while the high
// two bits are precomputed for both carry values and selected by the low
// half's carry-out.
module carry_select_slice4 (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   input  logic       i_cin,
   output logic [3:0] o_sum,
   output logic       o_cout
);
   logic [2:0] w_lo;
   logic [2:0] w_hi0;
   logic [2:0] w_hi1;
   logic [2:0] w_hi;

   assign w_lo   = {1'b0, i_a[1:0]} + {1'b0, i_b[1:0]} + {2'b00, i_cin};
   assign w_hi0  = {1'b0, i_a[3:2]} + {1'b0, i_b[3:2]};
   assign w_hi1  = {1'b0, i_a[3:2]} + {1'b0, i_b[3:2]} + 3'd1;
   assign w_hi   = w_lo[2] ? w_hi1 : w_hi0;
   assign o_sum  = {w_hi[1:0], w_lo[1:0]};
   assign o_cout = w_hi[2];
endmodule

module nibble_serial_adder #(
   parameter  int NIBBLES = 4,
   localparam int W       = 4 * NIBBLES
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         cin,
   output logic [W-1:0] s,
   output logic         cy,
   output logic         ovf,
   output logic         busy,
   output logic         done
);
   localparam int IW = $clog2(NIBBLES + 1);
   localparam logic [IW-1:0] IDX_LAST = IW'(NIBBLES - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t        r_state;
   logic [W-1:0]  r_a_sh;
   logic [W-1:0]  r_b_sh;
   logic          r_c;
   logic [IW-1:0] r_idx;
   logic [W-1:0]  r_s;
   logic          r_cy;
   logic          r_ovf;
   logic          r_am;
   logic          r_bm;

   logic [3:0]    w_nsum;
   logic          w_ncarry;
   logic [W-1:0]  w_s_next;

   carry_select_slice4 u_slice (
      .i_a    (r_a_sh[3:0]),
      .i_b    (r_b_sh[3:0]),
      .i_cin  (r_c),
      .o_sum  (w_nsum),
      .o_cout (w_ncarry)
   );

   // New nibble enters at the top of the result register; after NIBBLES
   // passes nibble 0 has walked down to bits [3:0]. Written as a shift of the
   // concatenation so it also holds for a single-nibble configuration.
   assign w_s_next = W'({w_nsum, r_s} >> 4);

   // NOTE: all state uses non-blocking assignments so every register samples
   // the pre-edge values; the async reset clears all of it, including outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= IDLE;
         r_a_sh  <= '0;
         r_b_sh  <= '0;
         r_c     <= 1'b0;
         r_idx   <= '0;
         r_s     <= '0;
         r_cy    <= 1'b0;
         r_ovf   <= 1'b0;
         r_am    <= 1'b0;
         r_bm    <= 1'b0;
      end else begin
         case (r_state)
            IDLE, DONE: begin
               if (start) begin
                  r_a_sh  <= a;
                  r_b_sh  <= b;
                  r_c     <= cin;
                  r_am    <= a[W-1];
                  r_bm    <= b[W-1];
                  r_idx   <= '0;
                  r_state <= RUN;
               end else begin
                  r_state <= IDLE;
               end
            end
            RUN: begin
               r_s    <= w_s_next;
               r_c    <= w_ncarry;
               r_a_sh <= r_a_sh >> 4;
               r_b_sh <= r_b_sh >> 4;
               r_idx  <= r_idx + 1'b1;
               if (r_idx == IDX_LAST) begin
                  // Last nibble: its sum bit 3 is the new result MSB.
                  r_cy    <= w_ncarry;
                  r_ovf   <= (r_am == r_bm) && (w_nsum[3] != r_am);
                  r_state <= DONE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign s    = r_s;
   assign cy   = r_cy;
   assign ovf  = r_ovf;
   assign busy = (r_state == RUN);
   assign done = (r_state == DONE);
endmodule

// File: tb/tb_nibble_serial_adder.sv
module tb_nibble_serial_adder;
  typedef struct packed {
    logic [31:0] s;
    logic        cy;
    logic        ovf;
  } exp_t;

  // Instance index: 0 -> NIBBLES=4 (directed), 1 -> NIBBLES=1, 2 -> NIBBLES=8
  logic        clk;
  logic        rst_n;
  logic        st [3];
  logic [31:0] ia [3];
  logic [31:0] ib [3];
  logic        ic [3];

  logic [15:0] s_d4;
  logic [3:0]  s_d1;
  logic [31:0] s_d8;
  logic [31:0] os [3];
  logic        ocy [3];
  logic        oov [3];
  logic        busy_w [3];
  logic        done_w [3];

  exp_t sb_q [3][$];
  int   n_chk = 0;
  int   n_err = 0;

  nibble_serial_adder #(.NIBBLES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .a(ia[0][15:0]), .b(ib[0][15:0]),
    .cin(ic[0]), .s(s_d4), .cy(ocy[0]), .ovf(oov[0]), .busy(busy_w[0]), .done(done_w[0]));
  nibble_serial_adder #(.NIBBLES(1)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .a(ia[1][3:0]), .b(ib[1][3:0]),
    .cin(ic[1]), .s(s_d1), .cy(ocy[1]), .ovf(oov[1]), .busy(busy_w[1]), .done(done_w[1]));
  nibble_serial_adder #(.NIBBLES(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .a(ib[2] ^ ib[2] ^ ia[2]), .b(ib[2]),
    .cin(ic[2]), .s(s_d8), .cy(ocy[2]), .ovf(oov[2]), .busy(busy_w[2]), .done(done_w[2]));

  assign os[0] = {16'h0, s_d4};
  assign os[1] = {28'h0, s_d1};
  assign os[2] = s_d8;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int wid(int k);
    return (k == 0) ? 16 : ((k == 1) ? 4 : 32);
  endfunction

  function automatic exp_t mk(logic [31:0] s, logic cy, logic ovf);
    exp_t e;
    e.s = s; e.cy = cy; e.ovf = ovf;
    return e;
  endfunction

  // Reference: plain wide addition, sign bits compared for overflow.
  function automatic exp_t model(int w, logic [31:0] a, logic [31:0] b, logic c);
    logic [32:0] full;
    logic [31:0] m;
    exp_t e;
    m    = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    full = {1'b0, a & m} + {1'b0, b & m} + {32'h0, c};
    e.s   = full[31:0] & m;
    e.cy  = full[w];
    e.ovf = (a[w-1] == b[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Waits for the DUT to be able to accept, drives start for one edge and
  // records the expected result at the accepting edge.
  task automatic issue(int k, logic [31:0] a, logic [31:0] b, logic c, exp_t e);
    int g = 0;
    @(negedge clk);
    while (busy_w[k] && g < 100) begin
      @(negedge clk);
      g++;
    end
    if (g >= 100) check($sformatf("issue_timeout dut%0d", k), 32'(g), 32'd0);
    ia[k] = a; ib[k] = b; ic[k] = c; st[k] = 1'b1;
    @(posedge clk);
    sb_q[k].push_back(e);
    #1 st[k] = 1'b0;
  endtask

  task automatic drain(int k);
    int g = 0;
    while (sb_q[k].size() != 0 && g < 400) begin
      @(negedge clk);
      g++;
    end
    check($sformatf("drain dut%0d pending", k), 32'(sb_q[k].size()), 32'd0);
  endtask

  task automatic rnd(int k, int n);
    logic [31:0] a, b, m;
    logic c;
    int w;
    w = wid(k);
    m = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
    for (int i = 0; i < n; i++) begin
      a = $urandom() & m;
      b = $urandom() & m;
      c = 1'($urandom_range(0, 1));
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue(k, a, b, c, model(w, a, b, c));
    end
  endtask

  // Monitors: compare on done, then require outputs stable until busy again.
  for (genvar g = 0; g < 3; g++) begin : g_mon
    initial begin
      exp_t        e;
      logic [31:0] hs;
      logic        hcy, hov;
      bit          hv;
      hv = 1'b0;
      forever begin
        @(negedge clk);
        if (!rst_n || busy_w[g]) begin
          hv = 1'b0;
        end else if (done_w[g]) begin
          if (sb_q[g].size() == 0) begin
            n_chk++;
            n_err++;
            $display("FAIL unexpected_done dut%0d: got done=1, expected no pending result", g);
          end else begin
            e = sb_q[g].pop_front();
            check($sformatf("s dut%0d", g), os[g], e.s);
            check($sformatf("cy dut%0d", g), {31'h0, ocy[g]}, {31'h0, e.cy});
            check($sformatf("ovf dut%0d", g), {31'h0, oov[g]}, {31'h0, e.ovf});
          end
          hs = os[g]; hcy = ocy[g]; hov = oov[g]; hv = 1'b1;
        end else if (hv) begin
          check($sformatf("hold dut%0d", g), {os[g][29:0], ocy[g], oov[g]},
                {hs[29:0], hcy, hov});
        end
      end
    end
  end

  initial begin
    int busy_cnt, done_cnt, done_at, g;
    for (int k = 0; k < 3; k++) begin
      st[k] = 1'b0; ia[k] = '0; ib[k] = '0; ic[k] = 1'b0;
    end
    rst_n = 1'b0;
    #22;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("reset s dut%0d", k), os[k], 32'h0);
      check($sformatf("reset flags dut%0d", k),
            {28'h0, ocy[k], oov[k], busy_w[k], done_w[k]}, 32'h0);
    end
    rst_n = 1'b1;

    // Latency: busy for 4 cycles, done on the 5th sample after the start edge.
    @(negedge clk);
    ia[0] = 32'h1234; ib[0] = 32'h4321; ic[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk);
    sb_q[0].push_back(mk(32'h5555, 1'b0, 1'b0));
    #1 st[0] = 1'b0;
    busy_cnt = 0; done_cnt = 0; done_at = 0;
    for (int i = 1; i <= 7; i++) begin
      @(negedge clk);
      if (busy_w[0]) busy_cnt++;
      if (done_w[0]) begin
        done_cnt++;
        if (done_at == 0) done_at = i;
      end
    end
    check("busy_cycles", 32'(busy_cnt), 32'd4);
    check("done_position", 32'(done_at), 32'd5);
    check("done_pulses", 32'(done_cnt), 32'd1);

    // Carry propagation and signed overflow corners.
    issue(0, 32'hFFFF, 32'h0001, 1'b0, mk(32'h0000, 1'b1, 1'b0));
    issue(0, 32'h0FFF, 32'h0000, 1'b1, mk(32'h1000, 1'b0, 1'b0));
    issue(0, 32'h7FFF, 32'h0001, 1'b0, mk(32'h8000, 1'b0, 1'b1));
    issue(0, 32'h8000, 32'h8000, 1'b0, mk(32'h0000, 1'b1, 1'b1));
    issue(0, 32'hFFFF, 32'hFFFF, 1'b0, mk(32'hFFFE, 1'b1, 1'b0));
    drain(0);

    // Start pulsed mid-run is ignored; start held across DONE restarts at once.
    issue(0, 32'h1111, 32'h2222, 1'b0, mk(32'h3333, 1'b0, 1'b0));
    @(negedge clk);
    @(negedge clk);
    ia[0] = 32'hAAAA; ib[0] = 32'h5555; ic[0] = 1'b1; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    @(negedge clk);
    ia[0] = 32'h0F0F; ib[0] = 32'hF0F0; ic[0] = 1'b1; st[0] = 1'b1;
    g = 0;
    while (!done_w[0] && g < 50) begin
      @(negedge clk);
      g++;
    end
    check("held_start_wait", 32'(done_w[0]), 32'd1);
    @(posedge clk);
    sb_q[0].push_back(mk(32'h0000, 1'b1, 1'b0));
    #1 st[0] = 1'b0;
    @(negedge clk);
    check("back_to_back_busy", {31'h0, busy_w[0]}, 32'd1);
    drain(0);

    // Reset dropped in the third RUN cycle.
    @(negedge clk);
    ia[0] = 32'h1111; ib[0] = 32'h1111; ic[0] = 1'b0; st[0] = 1'b1;
    @(posedge clk);
    #1 st[0] = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort s", os[0], 32'h0);
    check("abort flags", {28'h0, ocy[0], oov[0], busy_w[0], done_w[0]}, 32'h0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    repeat (6) begin
      @(negedge clk);
      if (done_w[0] || busy_w[0]) done_cnt++;
    end
    check("no_done_after_abort", 32'(done_cnt), 32'd0);
    issue(0, 32'h00FF, 32'h0F00, 1'b1, mk(32'h1000, 1'b0, 1'b0));
    drain(0);

    // Random regression on all three widths in parallel.
    fork
      rnd(0, 300);
      rnd(1, 400);
      rnd(2, 300);
    join
    for (int k = 0; k < 3; k++) drain(k);
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
